rf_multiport: RTL and testbench

RF_MULTIPORT -- requirements
Module: rf_multiport

---
 rtl/rf_multiport.sv | 161 ++++++++++++++++
 tb/tb_rf_multiport.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// -----------------------------------------------------------------------------
// rf_multiport
//
// Multi-lane register file with a pending-write scoreboard. Each issue lane
// owns two combinational read ports, one write port and one issue port. The
// issue port marks a destination register as busy (a write is in flight); the
// write port stores data and clears the busy mark. Reads see same-cycle writes
// through a bypass, so read-after-write latency is zero cycles.
//
// Register 0 is hard-wired: it reads as zero, ignores writes and is never busy.
// Addresses at or beyond DEPTH (possible when DEPTH is not a power of two) are
// treated like register 0.
//
// Parameters
//   DATA_WIDTH  register width in bits
//   DEPTH       number of registers
//   ADDR_WIDTH  address width, ceil(log2(DEPTH))
//   LANES       number of issue lanes, 1..4
//
// Ports (lane i occupies slice [i*W +: W] of every packed per-lane bus)
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset; clears all data and busy bits
//   wr_n      per-lane write enable, active low
//   wr_addr   per-lane write address
//   wr_data   per-lane write data
//   rd1_addr  per-lane address of read port 1
//   rd2_addr  per-lane address of read port 2
//   rd1_data  per-lane data of read port 1 (combinational)
//   rd2_data  per-lane data of read port 2 (combinational)
//   iss_n     per-lane issue strobe, active low
//   iss_addr  per-lane destination register being issued
//   rd1_busy  per-lane busy flag of the register on read port 1
//   rd2_busy  per-lane busy flag of the register on read port 2
// -----------------------------------------------------------------------------
module rf_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LANES      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              wr_n,
  input  logic [LANES*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   wr_data,
  input  logic [LANES*ADDR_WIDTH-1:0]   rd1_addr,
  input  logic [LANES*ADDR_WIDTH-1:0]   rd2_addr,
  output logic [LANES*DATA_WIDTH-1:0]   rd1_data,
  output logic [LANES*DATA_WIDTH-1:0]   rd2_data,
  input  logic [LANES-1:0]              iss_n,
  input  logic [LANES*ADDR_WIDTH-1:0]   iss_addr,
  output logic [LANES-1:0]              rd1_busy,
  output logic [LANES-1:0]              rd2_busy
);

  // Two read ports per lane, flattened as port index 2*lane + {0,1}.
  localparam int NPORTS = 2 * LANES;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;

  logic [ADDR_WIDTH-1:0] wr_addr_l  [LANES];
  logic [DATA_WIDTH-1:0] wr_data_l  [LANES];
  logic [ADDR_WIDTH-1:0] iss_addr_l [LANES];
  logic [LANES-1:0]      wr_valid;
  logic [LANES-1:0]      iss_valid;

  logic [ADDR_WIDTH-1:0] port_addr [NPORTS];
  logic [DATA_WIDTH-1:0] port_data [NPORTS];
  logic                  port_busy [NPORTS];

  // An address refers to real storage only if it is non-zero and below DEPTH;
  // everything else behaves like the hard-wired zero register.
  function automatic logic addr_usable(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (32'(a) < DEPTH);
  endfunction

  // Unpack the per-lane buses and qualify the write and issue strobes.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign wr_addr_l[l]   = wr_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_l[l]   = wr_data[l*DATA_WIDTH +: DATA_WIDTH];
    assign iss_addr_l[l]  = iss_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_valid[l]    = ~wr_n[l]  & addr_usable(wr_addr_l[l]);
    assign iss_valid[l]   = ~iss_n[l] & addr_usable(iss_addr_l[l]);
    assign port_addr[2*l]   = rd1_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_addr[2*l+1] = rd2_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd1_data[l*DATA_WIDTH +: DATA_WIDTH] = port_data[2*l];
    assign rd2_data[l*DATA_WIDTH +: DATA_WIDTH] = port_data[2*l+1];
    assign rd1_busy[l] = port_busy[2*l];
    assign rd2_busy[l] = port_busy[2*l+1];
  end

  // Next-state storage. Lanes are applied in ascending order so that the
  // highest-index lane overwrites lower lanes when several target one address.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
    end
    for (int l = 0; l < LANES; l++) begin
      if (wr_valid[l]) begin
        mem_d[wr_addr_l[l]] = wr_data_l[l];
      end
    end
  end

  // Next-state scoreboard. All clears are applied before any set, so an issue
  // and a write of the same register in one cycle leave it busy: the issue
  // belongs to a newer instruction than the one whose result is arriving.
  always_comb begin
    busy_d = busy_q;
    for (int l = 0; l < LANES; l++) begin
      if (wr_valid[l]) begin
        busy_d[wr_addr_l[l]] = 1'b0;
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (iss_valid[l]) begin
        busy_d[iss_addr_l[l]] = 1'b1;
      end
    end
  end

  // Read ports with write bypass. A matching same-cycle write supplies the
  // data and hides the busy bit it is about to clear; the highest matching
  // lane wins, mirroring the storage update.
  always_comb begin
    for (int k = 0; k < NPORTS; k++) begin
      port_data[k] = '0;
      port_busy[k] = 1'b0;
      if (addr_usable(port_addr[k])) begin
        port_data[k] = mem_q[port_addr[k]];
        port_busy[k] = busy_q[port_addr[k]];
        for (int l = 0; l < LANES; l++) begin
          if (wr_valid[l] && (wr_addr_l[l] == port_addr[k])) begin
            port_data[k] = wr_data_l[l];
            port_busy[k] = 1'b0;
          end
        end
      end
    end
  end

  // State registers. Reset clears everything immediately, discarding any
  // write or issue presented in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// -----------------------------------------------------------------------------
// tb_rf_multiport
//
// Self-checking bench for rf_multiport with LANES=2, DEPTH=32, DATA_WIDTH=32.
// A reference model holds the register contents and busy bits as plain arrays
// and predicts read data and busy flags from the current inputs.
// Inputs change 1 time unit after a rising edge and outputs are sampled
// 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_rf_multiport;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int LANES = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [LANES-1:0]    wr_n;
  logic [LANES*AW-1:0] wr_addr;
  logic [LANES*DW-1:0] wr_data;
  logic [LANES*AW-1:0] rd1_addr;
  logic [LANES*AW-1:0] rd2_addr;
  logic [LANES*DW-1:0] rd1_data;
  logic [LANES*DW-1:0] rd2_data;
  logic [LANES-1:0]    iss_n;
  logic [LANES*AW-1:0] iss_addr;
  logic [LANES-1:0]    rd1_busy;
  logic [LANES-1:0]    rd2_busy;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_mem  [DEPTH];
  logic          model_busy [DEPTH];

  rf_multiport #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .LANES(LANES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_n(wr_n),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd1_addr(rd1_addr),
    .rd2_addr(rd2_addr),
    .rd1_data(rd1_data),
    .rd2_data(rd2_data),
    .iss_n(iss_n),
    .iss_addr(iss_addr),
    .rd1_busy(rd1_busy),
    .rd2_busy(rd2_busy)
  );

  always #5 clk = ~clk;

  // Expected read data: reset forces zero, r0 is zero, otherwise the newest
  // same-cycle write (highest lane) or else the stored value.
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!reset || a == '0) return '0;
    v = model_mem[a];
    for (int l = 0; l < LANES; l++)
      if (!wr_n[l] && wr_addr[l*AW +: AW] == a) v = wr_data[l*DW +: DW];
    return v;
  endfunction

  // Expected busy flag: stored busy bit unless a same-cycle write clears it.
  function automatic logic exp_busy(input logic [AW-1:0] a);
    logic b;
    if (!reset || a == '0) return 1'b0;
    b = model_busy[a];
    for (int l = 0; l < LANES; l++)
      if (!wr_n[l] && wr_addr[l*AW +: AW] == a) b = 1'b0;
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      model_mem[r]  = '0;
      model_busy[r] = 1'b0;
    end
  endtask

  // Apply one rising edge to the model: writes land (later lanes overwrite
  // earlier ones), writes clear busy, then issues set busy.
  task automatic model_commit();
    logic [AW-1:0] a;
    for (int l = 0; l < LANES; l++) begin
      a = wr_addr[l*AW +: AW];
      if (!wr_n[l] && a != '0) begin
        model_mem[a]  = wr_data[l*DW +: DW];
        model_busy[a] = 1'b0;
      end
    end
    for (int l = 0; l < LANES; l++) begin
      a = iss_addr[l*AW +: AW];
      if (!iss_n[l] && a != '0) model_busy[a] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_commit();
    #1;
  endtask

  task automatic idle();
    wr_n  = '1;
    iss_n = '1;
  endtask

  task automatic drive_write(input int lane, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_n[lane] = 1'b0;
    wr_addr[lane*AW +: AW] = a;
    wr_data[lane*DW +: DW] = d;
  endtask

  task automatic drive_issue(input int lane, input logic [AW-1:0] a);
    iss_n[lane] = 1'b0;
    iss_addr[lane*AW +: AW] = a;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    rd1_addr = {5'd3, 5'd1};
    rd2_addr = {5'd31, 5'd0};
    #2;
    for (int l = 0; l < LANES; l++) begin
      checks++;
      if (rd1_data[l*DW +: DW] !== '0) begin
        errors++;
        $display("[TB] FAIL reset_rd1_data lane%0d: got %h expected 0", l, rd1_data[l*DW +: DW]);
      end
      checks++;
      if (rd2_data[l*DW +: DW] !== '0) begin
        errors++;
        $display("[TB] FAIL reset_rd2_data lane%0d: got %h expected 0", l, rd2_data[l*DW +: DW]);
      end
    end
    checks++;
    if (rd1_busy !== 2'b00 || rd2_busy !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_busy: got rd1=%b rd2=%b expected 00 00", rd1_busy, rd2_busy);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_rw();
    idle();
    drive_write(0, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    rd1_addr[1*AW +: AW] = 5'd5;
    rd2_addr[1*AW +: AW] = 5'd0;
    #1;
    checks++;
    if (rd1_data[1*DW +: DW] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL basic_rd1 lane1: got %h expected deadbeef", rd1_data[1*DW +: DW]);
    end
    checks++;
    if (rd2_data[1*DW +: DW] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL basic_rd2_r0 lane1: got %h expected 0", rd2_data[1*DW +: DW]);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    drive_write(0, 5'd7, 32'h1234);
    rd2_addr[1*AW +: AW] = 5'd7;
    #1;
    checks++;
    if (rd2_data[1*DW +: DW] !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle: got %h expected 1234", rd2_data[1*DW +: DW]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd2_data[1*DW +: DW] !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL bypass_stored: got %h expected 1234", rd2_data[1*DW +: DW]);
    end
    tick();
  endtask

  task automatic test_conflict();
    idle();
    drive_write(0, 5'd3, 32'hAAAA);
    drive_write(1, 5'd3, 32'h5555);
    rd1_addr[0 +: AW] = 5'd3;
    #1;
    checks++;
    if (rd1_data[0 +: DW] !== 32'h5555) begin
      errors++;
      $display("[TB] FAIL conflict_bypass: got %h expected 5555", rd1_data[0 +: DW]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd1_data[0 +: DW] !== 32'h5555) begin
      errors++;
      $display("[TB] FAIL conflict_stored: got %h expected 5555", rd1_data[0 +: DW]);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    drive_issue(0, 5'd9);
    tick();
    idle();
    rd1_addr[1*AW +: AW] = 5'd9;
    #1;
    checks++;
    if (rd1_busy[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_busy_after_issue: got %b expected 1", rd1_busy[1]);
    end
    drive_write(1, 5'd9, 32'h42);
    rd1_addr[0 +: AW] = 5'd9;
    #1;
    checks++;
    if (rd1_busy[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sb_busy_write_cycle: got %b expected 0", rd1_busy[0]);
    end
    checks++;
    if (rd1_data[0 +: DW] !== 32'h42) begin
      errors++;
      $display("[TB] FAIL sb_data_write_cycle: got %h expected 42", rd1_data[0 +: DW]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd1_busy !== 2'b00) begin
      errors++;
      $display("[TB] FAIL sb_busy_after_write: got %b expected 00", rd1_busy);
    end
    drive_issue(0, 5'd9);
    drive_write(1, 5'd9, 32'h43);
    tick();
    idle();
    #1;
    checks++;
    if (rd1_busy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_set_wins: got %b expected 1", rd1_busy[0]);
    end
    checks++;
    if (rd1_data[0 +: DW] !== 32'h43) begin
      errors++;
      $display("[TB] FAIL sb_set_wins_data: got %h expected 43", rd1_data[0 +: DW]);
    end
    drive_write(0, 5'd9, 32'h44);
    tick();
    idle();
  endtask

  task automatic test_zero_reg();
    idle();
    drive_write(0, 5'd0, 32'hFFFFFFFF);
    drive_issue(0, 5'd0);
    rd1_addr[0 +: AW] = 5'd0;
    rd2_addr[0 +: AW] = 5'd0;
    #1;
    checks++;
    if (rd1_data[0 +: DW] !== 32'h0 || rd1_busy[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_same_cycle: got data=%h busy=%b expected 0 0", rd1_data[0 +: DW], rd1_busy[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd2_data[0 +: DW] !== 32'h0 || rd2_busy[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_after: got data=%h busy=%b expected 0 0", rd2_data[0 +: DW], rd2_busy[0]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 300; n++) begin
      for (int l = 0; l < LANES; l++) begin
        wr_n[l]  = ($urandom_range(0, 2) == 0);
        iss_n[l] = ($urandom_range(0, 1) == 0);
        wr_addr[l*AW +: AW]  = 5'($urandom_range(0, 15));
        iss_addr[l*AW +: AW] = 5'($urandom_range(0, 15));
        rd1_addr[l*AW +: AW] = 5'($urandom_range(0, 15));
        rd2_addr[l*AW +: AW] = 5'($urandom_range(0, 15));
        wr_data[l*DW +: DW]  = $urandom;
      end
      #1;
      for (int l = 0; l < LANES; l++) begin
        a = rd1_addr[l*AW +: AW];
        checks++;
        if (rd1_data[l*DW +: DW] !== exp_data(a) || rd1_busy[l] !== exp_busy(a)) begin
          errors++;
          $display("[TB] FAIL random_rd1 cycle%0d lane%0d r%0d: got %h/%b expected %h/%b",
                   n, l, a, rd1_data[l*DW +: DW], rd1_busy[l], exp_data(a), exp_busy(a));
        end
        a = rd2_addr[l*AW +: AW];
        checks++;
        if (rd2_data[l*DW +: DW] !== exp_data(a) || rd2_busy[l] !== exp_busy(a)) begin
          errors++;
          $display("[TB] FAIL random_rd2 cycle%0d lane%0d r%0d: got %h/%b expected %h/%b",
                   n, l, a, rd2_data[l*DW +: DW], rd2_busy[l], exp_data(a), exp_busy(a));
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    for (int r = 1; r < DEPTH; r++) begin
      drive_write(0, 5'(r), $urandom | 32'h1);
      drive_issue(1, 5'(r));
      tick();
    end
    idle();
    rd1_addr = {5'd9, 5'd5};
    rd2_addr = {5'd31, 5'd1};
    #1;
    checks++;
    if (rd1_data[0 +: DW] !== model_mem[5] || rd1_busy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL populate_r5: got %h/%b expected %h/1", rd1_data[0 +: DW], rd1_busy[0], model_mem[5]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rd1_data !== '0 || rd2_data !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset_data: got rd1=%h rd2=%h expected 0", rd1_data, rd2_data);
    end
    checks++;
    if (rd1_busy !== 2'b00 || rd2_busy !== 2'b00) begin
      errors++;
      $display("[TB] FAIL async_reset_busy: got rd1=%b rd2=%b expected 00 00", rd1_busy, rd2_busy);
    end
    drive_write(0, 5'd4, 32'hCAFE);
    drive_issue(1, 5'd6);
    tick();
    idle();
    reset = 1'b1;
    tick();
    for (int r = 0; r < DEPTH; r += 2) begin
      rd1_addr[0 +: AW] = 5'(r);
      rd2_addr[0 +: AW] = 5'(r + 1);
      #1;
      checks++;
      if (rd1_data[0 +: DW] !== '0 || rd2_data[0 +: DW] !== '0 ||
          rd1_busy[0] !== 1'b0 || rd2_busy[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset r%0d/r%0d: got %h/%b %h/%b expected all 0",
                 r, r + 1, rd1_data[0 +: DW], rd1_busy[0], rd2_data[0 +: DW], rd2_busy[0]);
      end
    end
  endtask

  initial begin
    wr_n     = '1;
    iss_n    = '1;
    wr_addr  = '0;
    wr_data  = '0;
    iss_addr = '0;
    rd1_addr = '0;
    rd2_addr = '0;
    model_reset();
    test_reset();
    test_basic_rw();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_zero_reg();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
